// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_pkg
// Brief    : Shared constants, FSM encodings and helpers for the L1 data cache.
// Revision : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

  localparam int DC_NUM_LINES = 64;
  localparam int DC_OFFSET_W  = 5;
  localparam int DC_WORD_W    = 32;
  localparam int DC_BLOCK_W   = 256;

  typedef logic [2:0] dc_state_t;

  localparam logic [2:0] DC_IDLE       = 3'd0;
  localparam logic [2:0] DC_WRITEBACK  = 3'd1;
  localparam logic [2:0] DC_REFILL     = 3'd2;
  localparam logic [2:0] DC_FLUSH_SCAN = 3'd3;
  localparam logic [2:0] DC_FLUSH_WB   = 3'd4;
  localparam logic [2:0] DC_FLUSH_DONE = 3'd5;

  // Aligns a byte address down to its 32-byte block.
  function automatic logic [31:0] dc_block_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFE0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_store_merge.sv
`default_nettype none
// ============================================================================
// Module   : dcache_store_merge
// Brief    : Merges a right-justified 1..4 byte store into a big-endian word.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_store_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  store_size,
  input  logic [1:0]  byte_offset,
  output logic [31:0] merged_word
);

  int w_n_bytes;
  int w_pos;

  // Byte 0 is the MSB; bytes that would fall past offset 3 are discarded.
  always_comb begin
    merged_word = old_word;
    w_n_bytes   = (store_size == 2'd0) ? 4 : int'(store_size);
    w_pos       = 0;
    for (int i = 0; i < 4; i++) begin
      w_pos = int'(byte_offset) + i;
      if ((i < w_n_bytes) && (w_pos < 4)) begin
        merged_word[8*(3-w_pos) +: 8] = store_data[8*(w_n_bytes-1-i) +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Brief    : Direct-mapped, write-back, write-allocate L1 data cache with flush.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES = DC_NUM_LINES
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           data_address_2DC,
  input  logic                  read_2DC,
  input  logic                  write_2DC,
  input  logic [31:0]           data_write_2DC,
  input  logic [1:0]            data_write_size_2DC,
  input  logic                  flush_2DC,
  output logic [31:0]           data_read_fDC,
  output logic                  data_valid_fDC,
  output logic                  flush_done_fDC,
  output logic [31:0]           data_address_2DM,
  output logic                  dBlkRead,
  input  logic [DC_BLOCK_W-1:0] block_read_fDM,
  input  logic                  block_read_fDM_valid,
  output logic                  dBlkWrite,
  output logic [DC_BLOCK_W-1:0] block_write_2DM,
  input  logic                  block_write_fDM_valid
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - DC_OFFSET_W - INDEX_W;

  dc_state_t              r_state;
  logic [INDEX_W-1:0]     r_scan;
  logic [DC_BLOCK_W-1:0]  r_data [NUM_LINES];
  logic [TAG_W-1:0]       r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0]   r_valid;
  logic [NUM_LINES-1:0]   r_dirty;

  logic [TAG_W-1:0]       w_tag;
  logic [INDEX_W-1:0]     w_index;
  logic [2:0]             w_word;
  logic [DC_BLOCK_W-1:0]  w_line;
  logic [DC_WORD_W-1:0]   w_old_word;
  logic [DC_WORD_W-1:0]   w_merged;
  logic                   w_req;
  logic                   w_hit;
  logic                   w_hit_write;
  logic [INDEX_W-1:0]     w_wb_index;

  assign w_tag      = data_address_2DC[31 -: TAG_W];
  assign w_index    = data_address_2DC[DC_OFFSET_W +: INDEX_W];
  assign w_word     = data_address_2DC[4:2];
  assign w_line     = r_data[w_index];
  assign w_old_word = w_line[DC_WORD_W*w_word +: DC_WORD_W];
  assign w_req      = read_2DC || write_2DC;
  assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_hit_write = (r_state == DC_IDLE) && write_2DC && w_hit;

  // The victim is the requested index on a miss, or the scan index while flushing.
  assign w_wb_index = (r_state == DC_FLUSH_WB) ? r_scan : w_index;

  dcache_store_merge u_store_merge (
    .old_word    (w_old_word),
    .store_data  (data_write_2DC),
    .store_size  (data_write_size_2DC),
    .byte_offset (data_address_2DC[1:0]),
    .merged_word (w_merged)
  );

  assign data_valid_fDC  = (r_state == DC_IDLE) && w_req && w_hit;
  assign data_read_fDC   = data_valid_fDC ? w_old_word : '0;
  assign dBlkRead        = (r_state == DC_REFILL);
  assign dBlkWrite       = (r_state == DC_WRITEBACK) || (r_state == DC_FLUSH_WB);
  assign block_write_2DM = dBlkWrite ? r_data[w_wb_index] : '0;
  assign flush_done_fDC  = (r_state == DC_FLUSH_DONE) && flush_2DC;

  always_comb begin
    data_address_2DM = '0;
    case (r_state)
      DC_WRITEBACK, DC_FLUSH_WB:
        data_address_2DM = {r_tag[w_wb_index], w_wb_index, {DC_OFFSET_W{1'b0}}};
      DC_REFILL:
        data_address_2DM = dc_block_addr(data_address_2DC);
      default: ;
    endcase
  end

  // Line data and tags carry no reset; the valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if ((r_state == DC_REFILL) && block_read_fDM_valid) begin
        r_data[w_index] <= block_read_fDM;
        r_tag[w_index]  <= w_tag;
      end else if (w_hit_write) begin
        r_data[w_index][DC_WORD_W*w_word +: DC_WORD_W] <= w_merged;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= DC_IDLE;
      r_scan  <= '0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        DC_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (write_2DC) begin
                r_dirty[w_index] <= 1'b1;
              end
            end else if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state <= DC_WRITEBACK;
            end else begin
              r_state <= DC_REFILL;
            end
          end else if (flush_2DC) begin
            r_scan  <= '0;
            r_state <= DC_FLUSH_SCAN;
          end
        end
        DC_WRITEBACK: begin
          if (block_write_fDM_valid) begin
            r_dirty[w_index] <= 1'b0;
            r_state          <= DC_REFILL;
          end
        end
        DC_REFILL: begin
          if (block_read_fDM_valid) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
            r_state          <= DC_IDLE;
          end
        end
        DC_FLUSH_SCAN: begin
          if (r_valid[r_scan] && r_dirty[r_scan]) begin
            r_state <= DC_FLUSH_WB;
          end else begin
            r_valid[r_scan] <= 1'b0;
            if (r_scan == INDEX_W'(NUM_LINES - 1)) begin
              r_state <= DC_FLUSH_DONE;
            end else begin
              r_scan <= r_scan + INDEX_W'(1);
            end
          end
        end
        DC_FLUSH_WB: begin
          // Return to the same index; the now-clean line is invalidated there.
          if (block_write_fDM_valid) begin
            r_dirty[r_scan] <= 1'b0;
            r_state         <= DC_FLUSH_SCAN;
          end
        end
        DC_FLUSH_DONE: begin
          if (!flush_2DC) begin
            r_state <= DC_IDLE;
          end
        end
        default: r_state <= DC_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache
// Brief    : Scoreboard bench for data_cache with a latency-configurable memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_2DC;
  logic         read_2DC, write_2DC, flush_2DC;
  logic [31:0]  data_write_2DC;
  logic [1:0]   data_write_size_2DC;
  logic [31:0]  data_read_fDC;
  logic         data_valid_fDC, flush_done_fDC;
  logic [31:0]  data_address_2DM;
  logic         dBlkRead, dBlkWrite;
  logic [255:0] block_read_fDM, block_write_2DM;
  logic         block_read_fDM_valid, block_write_fDM_valid;

  data_cache #(.NUM_LINES(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .data_address_2DC(data_address_2DC), .read_2DC(read_2DC), .write_2DC(write_2DC),
    .data_write_2DC(data_write_2DC), .data_write_size_2DC(data_write_size_2DC),
    .flush_2DC(flush_2DC), .data_read_fDC(data_read_fDC), .data_valid_fDC(data_valid_fDC),
    .flush_done_fDC(flush_done_fDC), .data_address_2DM(data_address_2DM),
    .dBlkRead(dBlkRead), .block_read_fDM(block_read_fDM),
    .block_read_fDM_valid(block_read_fDM_valid), .dBlkWrite(dBlkWrite),
    .block_write_2DM(block_write_2DM), .block_write_fDM_valid(block_write_fDM_valid)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;
  int n_refills = 0;
  int both_viol = 0;
  int rd_zero_viol = 0;

  logic [32:0]  exp_q[$];   // bit 32 = compare data, [31:0] = expected load data
  string        name_q[$];
  logic [31:0]  wb_addr_q[$];
  logic [255:0] wb_data_q[$];
  logic [255:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Untouched memory holds each word's own byte address.
  function automatic logic [255:0] mem_read(input logic [31:0] a);
    logic [255:0] b;
    if (mem.exists(a)) return mem[a];
    for (int w = 0; w < 8; w++) b[32*w +: 32] = a + 32'(4*w);
    return b;
  endfunction

  // Memory responder: answers a held request after 'lat' cycles.
  initial begin
    int rc, wc;
    rc = 0; wc = 0;
    block_read_fDM = '0; block_read_fDM_valid = 1'b0; block_write_fDM_valid = 1'b0;
    forever begin
      @(negedge CLK);
      block_read_fDM = '0; block_read_fDM_valid = 1'b0; block_write_fDM_valid = 1'b0;
      if (dBlkRead === 1'b1 && dBlkWrite === 1'b1) both_viol++;
      if (data_valid_fDC === 1'b0 && data_read_fDC !== 32'h0) rd_zero_viol++;
      if (dBlkRead === 1'b1) begin
        rc++;
        if (rc >= lat) begin
          block_read_fDM = mem_read(data_address_2DM);
          block_read_fDM_valid = 1'b1;
          n_refills++;
          rc = 0;
        end
      end else rc = 0;
      if (dBlkWrite === 1'b1) begin
        wc++;
        if (wc >= lat) begin
          wb_addr_q.push_back(data_address_2DM);
          wb_data_q.push_back(block_write_2DM);
          mem[data_address_2DM] = block_write_2DM;
          block_write_fDM_valid = 1'b1;
          wc = 0;
        end
      end else wc = 0;
    end
  end

  // Scoreboard monitor: every completed access consumes one expectation.
  initial begin
    logic [32:0] e;
    string nm;
    forever begin
      @(negedge CLK);
      if (data_valid_fDC === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected data_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e[32]) chk(nm, data_read_fDC, e[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d,
                       input logic [1:0] sz, input string nm, input logic [31:0] exp,
                       input bit care, input bit push);
    if (push) begin
      exp_q.push_back({care, exp});
      name_q.push_back(nm);
    end
    data_address_2DC = a; read_2DC = rd; write_2DC = wr;
    data_write_2DC = d; data_write_size_2DC = sz;
  endtask

  task automatic finish_req(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (data_valid_fDC !== 1'b1 && cyc < 200);
    if (data_valid_fDC !== 1'b1) chk("access timeout", 0, 1);
    @(posedge CLK); #1;
    read_2DC = 0; write_2DC = 0; data_address_2DC = '0;
    data_write_2DC = '0; data_write_size_2DC = '0;
  endtask

  task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d,
                        input logic [1:0] sz, input string nm, input logic [31:0] exp,
                        input bit care, input int exp_cyc);
    int c;
    issue(a, rd, wr, d, sz, nm, exp, care, 1'b1);
    finish_req(c);
    chk({nm, " cycles"}, c, exp_cyc);
  endtask

  logic [31:0] st_addr [4] = '{32'h1005, 32'h1008, 32'h100C, 32'h1012};
  logic [31:0] st_data [4] = '{32'h000000AB, 32'h00001234, 32'hCAFEF00D, 32'h00A1B2C3};
  logic [1:0]  st_size [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
  logic [31:0] rd_addr [5] = '{32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014};
  logic [31:0] rd_exp  [5] = '{32'hDEABBEEF, 32'h12341008, 32'hCAFEF00D, 32'h0000A1B2, 32'h77001014};

  initial begin
    logic [255:0] blk;
    int c, r0, bad;
    blk = mem_read(32'h1000);
    blk[63:32] = 32'hDEADBEEF;
    mem[32'h1000] = blk;

    RESET = 1'b0; flush_2DC = 1'b0;
    read_2DC = 0; write_2DC = 0; data_address_2DC = '0;
    data_write_2DC = '0; data_write_size_2DC = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset data_valid", data_valid_fDC, 0);
    chk("reset data_read", data_read_fDC, 0);
    chk("reset dBlkRead", dBlkRead, 0);
    chk("reset dBlkWrite", dBlkWrite, 0);
    chk("reset flush_done", flush_done_fDC, 0);
    chk("reset mem addr", data_address_2DM, 0);
    chk("reset block_write", block_write_2DM, 0);
    @(posedge CLK); #1 RESET = 1'b1;

    // Cold miss, refill, then hits
    issue(32'h1004, 1, 0, 0, 0, "cold read", 32'hDEADBEEF, 1, 1);
    @(negedge CLK); @(negedge CLK);
    chk("cold dBlkRead", dBlkRead, 1);
    chk("cold dBlkWrite", dBlkWrite, 0);
    chk("cold refill addr", data_address_2DM, 32'h1000);
    finish_req(c);
    chk("cold valid one cycle after refill", c, 1);
    r0 = n_refills;
    access(32'h1004, 1, 0, 0, 0, "hit read w1", 32'hDEADBEEF, 1, 1);
    access(32'h1000, 1, 0, 0, 0, "hit read w0", 32'h00001000, 1, 1);
    chk("hits issue no refill", n_refills, r0);

    // Store merges on hits, then read&write together
    for (int i = 0; i < 4; i++)
      access(st_addr[i], 0, 1, st_data[i], st_size[i], "hit store", 0, 0, 1);
    access(32'h1014, 1, 1, 32'h77, 2'd1, "read+write pre-word", 32'h00001014, 1, 1);
    for (int i = 0; i < 5; i++)
      access(rd_addr[i], 1, 0, 0, 0, "merged word", rd_exp[i], 1, 1);

    // Conflict miss evicts the dirty line before refilling
    issue(32'h1804, 1, 0, 0, 0, "conflict read", 32'h00001804, 1, 1);
    @(negedge CLK); @(negedge CLK);
    chk("wb dBlkWrite", dBlkWrite, 1);
    chk("wb dBlkRead low", dBlkRead, 0);
    chk("wb addr", data_address_2DM, 32'h1000);
    chk("wb line", block_write_2DM, {32'h0000101C, 32'h00001018, 32'h77001014, 32'h0000A1B2,
                                     32'hCAFEF00D, 32'h12341008, 32'hDEABBEEF, 32'h00001000});
    @(negedge CLK);
    chk("refill after wb dBlkRead", dBlkRead, 1);
    chk("refill after wb dBlkWrite low", dBlkWrite, 0);
    chk("refill after wb addr", data_address_2DM, 32'h1800);
    finish_req(c);
    chk("wb count", wb_addr_q.size(), 1);
    access(32'h1004, 1, 0, 0, 0, "reload written-back", 32'hDEABBEEF, 1, 3);
    chk("clean victim no wb", wb_addr_q.size(), 1);

    // Three dirty lines (incl. last index) plus one clean, then flush
    access(32'h1000, 0, 1, 32'h11111111, 2'd0, "dirty idx0", 0, 0, 1);
    access(32'h2024, 0, 1, 32'h22222222, 2'd0, "dirty idx1", 0, 0, 3);
    access(32'h3FFC, 0, 1, 32'h33333333, 2'd0, "dirty idx63", 0, 0, 3);
    access(32'h0040, 1, 0, 0, 0, "clean idx2", 32'h00000040, 1, 3);
    wb_addr_q.delete(); wb_data_q.delete();
    flush_2DC = 1'b1;
    c = 0;
    do begin @(negedge CLK); c++; end while (flush_done_fDC !== 1'b1 && c < 400);
    chk("flush_done", flush_done_fDC, 1);
    chk("flush wb count", wb_addr_q.size(), 3);
    if (wb_addr_q.size() == 3) begin
      chk("flush wb0 addr", wb_addr_q[0], 32'h1000);
      chk("flush wb1 addr", wb_addr_q[1], 32'h2020);
      chk("flush wb2 addr", wb_addr_q[2], 32'h3FE0);
      chk("flush wb0 word0", wb_data_q[0][31:0], 32'h11111111);
      chk("flush wb1 word1", wb_data_q[1][63:32], 32'h22222222);
      chk("flush wb2 word7", wb_data_q[2][255:224], 32'h33333333);
    end
    @(negedge CLK);
    chk("flush_done held", flush_done_fDC, 1);
    @(posedge CLK); #1 flush_2DC = 1'b0;
    @(negedge CLK);
    chk("flush_done drops", flush_done_fDC, 0);
    @(posedge CLK); #1;
    access(32'h1000, 1, 0, 0, 0, "post-flush idx0", 32'h11111111, 1, 3);
    access(32'h2024, 1, 0, 0, 0, "post-flush idx1", 32'h22222222, 1, 3);
    access(32'h0040, 1, 0, 0, 0, "post-flush idx2", 32'h00000040, 1, 3);

    // Reset in the middle of a refill
    access(32'h1000, 1, 0, 0, 0, "pre-reset hit", 32'h11111111, 1, 1);
    lat = 10;
    issue(32'h5000, 1, 0, 0, 0, "aborted", 0, 0, 0);
    @(negedge CLK); @(negedge CLK);
    chk("abort refill started", dBlkRead, 1);
    @(posedge CLK); #1;
    RESET = 1'b0; read_2DC = 0; data_address_2DC = '0;
    @(posedge CLK); @(negedge CLK);
    chk("abort dBlkRead", dBlkRead, 0);
    chk("abort dBlkWrite", dBlkWrite, 0);
    chk("abort mem addr", data_address_2DM, 0);
    chk("abort data_valid", data_valid_fDC, 0);
    @(posedge CLK); #1 RESET = 1'b1; lat = 1;
    access(32'h1000, 1, 0, 0, 0, "after reset misses", 32'h11111111, 1, 3);

    // Stalled memory: request held stable for 20 cycles
    lat = 20;
    issue(32'h6000, 1, 0, 0, 0, "stalled read", 32'h00006000, 1, 1);
    @(negedge CLK);
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (!(dBlkRead === 1'b1 && dBlkWrite === 1'b0 && data_valid_fDC === 1'b0 &&
            data_address_2DM === 32'h6000)) bad++;
    end
    chk("stall request stable", bad, 0);
    finish_req(c);
    chk("stall completes next cycle", c, 1);
    lat = 1;

    // Write miss allocates
    access(32'h7004, 0, 1, 32'hABCD0123, 2'd0, "write miss", 0, 0, 3);
    access(32'h7004, 1, 0, 0, 0, "write-allocated read", 32'hABCD0123, 1, 1);

    chk("never both requests", both_viol, 0);
    chk("read data zero when idle", rd_zero_viol, 0);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
